// File: rtl/conv_pkg.sv
// Shared definitions for the pixel feed path.
//   COORD_W / GRAY_W     : coordinate and grayscale widths
//   H_PIXELS_DEF / V_PIXELS_DEF : default frame geometry
//   FIFO_DEPTH / FIFO_W  : output FIFO geometry (gray + eol + eof)
//   state_t              : feed controller FSM states
//   pix_t                : one FIFO entry
package conv_pkg;

  localparam int unsigned COORD_W      = 10;
  localparam int unsigned GRAY_W       = 4;
  localparam int unsigned H_PIXELS_DEF = 640;
  localparam int unsigned V_PIXELS_DEF = 480;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned FIFO_W       = GRAY_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [GRAY_W-1:0] data;
    logic              eol;
    logic              eof;
  } pix_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous 4-entry FIFO holding captured pixels with their eol/eof flags.
//   clk, reset : clock, synchronous active-high reset (clears storage too)
//   push_i, din_i : write strobe and entry
//   pop_i      : read strobe (ignored when empty)
//   dout_o     : head entry, combinational from storage
//   empty_o    : FIFO holds no entries
//   count_o    : occupancy 0..4
module pixel_fifo
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [FIFO_W-1:0] din_i,
  input  logic              pop_i,
  output logic [FIFO_W-1:0] dout_o,
  output logic              empty_o,
  output logic [2:0]        count_o
);

  logic [FIFO_W-1:0] mem_q [FIFO_DEPTH];
  logic [1:0]        wr_ptr_q;
  logic [1:0]        rd_ptr_q;
  logic [2:0]        count_q;
  logic [2:0]        count_d;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop_i && (count_q != 3'd0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 3'(FIFO_DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 3'd0);
  assign count_o = count_q;

endmodule

// File: rtl/pixel_feed_controller.sv
// Scans one frame of coordinates into a grayscale generator and streams the
// returned pixels to a consumer with valid/ready flow control.
//   clk, reset          : clock, synchronous active-high reset
//   frame_start         : pulse that starts one frame scan from IDLE
//   pixel_en            : enable gating coordinate issue
//   gen_x, gen_y        : coordinate presented to the generator
//   gen_tick            : high the cycle after each issue
//   gen_color           : generator result, captured two cycles after issue
//   pix_data/eol/eof    : FIFO head pixel and its line/frame end flags
//   pix_valid/pix_ready : output handshake
//   busy, frame_done    : not-IDLE indicator, end-of-frame pulse
module pixel_feed_controller
  import conv_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_PIXELS = V_PIXELS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pixel_en,
  output logic [COORD_W-1:0] gen_x,
  output logic [COORD_W-1:0] gen_y,
  output logic               gen_tick,
  input  logic [GRAY_W-1:0]  gen_color,
  output logic [GRAY_W-1:0]  pix_data,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_PIXELS - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_PIXELS - 1);

  state_t             state_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               done_q;

  logic               tick_q;
  logic               cap_q;
  logic               eol_p1_q;
  logic               eof_p1_q;
  logic               eol_p2_q;
  logic               eof_p2_q;
  logic [1:0]         inflight_q;
  logic [1:0]         inflight_d;

  logic               x_end;
  logic               last_coord;
  logic               issue;
  logic               pop;
  logic               fifo_empty;
  logic [2:0]         occ;
  logic [FIFO_W-1:0]  fifo_din;
  pix_t               fifo_dout;

  assign x_end      = (x_q == X_LAST);
  assign last_coord = x_end && (y_q == Y_LAST);

  // x_q/y_q hold the coordinate to issue next, so an issue presents it in the
  // same cycle; credits count both generator latency slots and FIFO entries.
  assign issue = (state_q == RUN) && pixel_en && ((3'(inflight_q) + occ) < 3'd4);
  assign pop   = !fifo_empty && pix_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // done_q high means this is the frame_done cycle: start is ignored.
          if (frame_start && !done_q) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (x_end) begin
              x_q <= '0;
              y_q <= last_coord ? '0 : y_q + COORD_W'(1);
            end else begin
              x_q <= x_q + COORD_W'(1);
            end
            if (last_coord) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && fifo_dout.eof) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-stage issue pipeline matching generator latency; stage 2 is the capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= 1'b0;
      cap_q      <= 1'b0;
      eol_p1_q   <= 1'b0;
      eof_p1_q   <= 1'b0;
      eol_p2_q   <= 1'b0;
      eof_p2_q   <= 1'b0;
      inflight_q <= '0;
    end else begin
      tick_q     <= issue;
      cap_q      <= tick_q;
      eol_p1_q   <= issue && x_end;
      eof_p1_q   <= issue && last_coord;
      eol_p2_q   <= eol_p1_q;
      eof_p2_q   <= eof_p1_q;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, cap_q})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  assign fifo_din = {gen_color, eol_p2_q, eof_p2_q};

  pixel_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cap_q),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (occ)
  );

  assign gen_x      = x_q;
  assign gen_y      = y_q;
  assign gen_tick   = tick_q;
  assign pix_data   = fifo_dout.data;
  assign pix_eol    = fifo_dout.eol;
  assign pix_eof    = fifo_dout.eof;
  assign pix_valid  = !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_feed_controller.sv
// Self-checking bench for pixel_feed_controller on an 8x4 frame.
`timescale 1ns/1ps
module tb_pixel_feed_controller;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NPIX = H * V;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       pixel_en;
  logic [9:0] gen_x;
  logic [9:0] gen_y;
  logic       gen_tick;
  logic [3:0] gen_color;
  logic [3:0] pix_data;
  logic       pix_eol;
  logic       pix_eof;
  logic       pix_valid;
  logic       pix_ready;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  pixel_feed_controller #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pixel_en    (pixel_en),
    .gen_x       (gen_x),
    .gen_y       (gen_y),
    .gen_tick    (gen_tick),
    .gen_color   (gen_color),
    .pix_data    (pix_data),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // Generator model: result for the presented coordinate appears two cycles later.
  function automatic logic [3:0] color_of(input int x, input int y);
    return 4'((x * 3 + y * 5 + (x >> 2)) & 15);
  endfunction

  logic [9:0] s1x, s1y, s2x, s2y;
  always @(posedge clk) begin
    s1x <= gen_x;
    s1y <= gen_y;
    s2x <= s1x;
    s2y <= s1y;
  end
  assign gen_color = color_of(int'(s2x), int'(s2y));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records issues (seen via gen_tick), accepted pixels, frame_done pulses.
  int iss_x[$], iss_y[$], iss_cyc[$];
  int acc_v[$], acc_cyc[$];
  int done_cyc[$];
  int en_viol = 0;
  int outstanding = 0;
  int max_out = 0;
  logic [9:0] px, py;
  logic pen;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
    end else begin
      if (gen_tick) begin
        iss_x.push_back(int'(px));
        iss_y.push_back(int'(py));
        iss_cyc.push_back(cyc - 1);
        if (pen !== 1'b1) en_viol++;
        outstanding++;
      end
      if (pix_valid && pix_ready) begin
        acc_v.push_back(int'({pix_data, pix_eol, pix_eof}));
        acc_cyc.push_back(cyc);
        outstanding--;
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (outstanding > max_out) max_out = outstanding;
    end
    px  = gen_x;
    py  = gen_y;
    pen = pixel_en;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: all enabled; 1: random en/ready; 2: en 1 cycle in 4; 3: 20-cycle ready stall
  task automatic run_frame(input int mode, input bit poke_run, input bit poke_done);
    int  base_i;
    int  base_a;
    int  base_d;
    int  fs_cyc;
    int  k;
    int  stall_ticks;
    int  n;
    int  eof_idx;
    bit  done;
    base_i = iss_x.size();
    base_a = acc_v.size();
    base_d = done_cyc.size();
    @(posedge clk); #1;
    frame_start = 1'b1;
    fs_cyc      = cyc;
    pixel_en    = (mode != 2);
    pix_ready   = 1'b1;
    k = 0;
    stall_ticks = 0;
    done = 1'b0;
    while (!done && k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (frame_done) begin
        done = 1'b1;
        frame_start = poke_done;
      end else begin
        frame_start = poke_run && (k == 10);
      end
      case (mode)
        1: begin
          pixel_en  = ($urandom_range(0, 3) != 0);
          pix_ready = ($urandom_range(0, 2) != 0);
        end
        2: begin
          pixel_en  = ((k % 4) == 0);
          pix_ready = 1'b1;
        end
        3: begin
          pixel_en  = 1'b1;
          pix_ready = !(k >= 10 && k < 30);
        end
        default: begin
          pixel_en  = 1'b1;
          pix_ready = 1'b1;
        end
      endcase
      if (mode == 3 && k >= 16 && k < 30 && gen_tick) stall_ticks++;
    end
    chk($sformatf("m%0d_frame_done_seen", mode), 32'(done), 32'd1);
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk($sformatf("m%0d_idle_after", mode), 32'(busy), 32'd0);
    chk($sformatf("m%0d_issue_count", mode), 32'(iss_x.size() - base_i), 32'(NPIX));
    chk($sformatf("m%0d_pixel_count", mode), 32'(acc_v.size() - base_a), 32'(NPIX));
    chk($sformatf("m%0d_done_count", mode), 32'(done_cyc.size() - base_d), 32'd1);
    n = iss_x.size() - base_i;
    for (int i = 0; i < NPIX && i < n; i++) begin
      chk($sformatf("m%0d_coord%0d", mode, i),
          32'((iss_x[base_i + i] << 10) | iss_y[base_i + i]),
          32'(((i % H) << 10) | (i / H)));
    end
    n = acc_v.size() - base_a;
    eof_idx = -1;
    for (int i = 0; i < NPIX && i < n; i++) begin
      int ex;
      ex = (int'(color_of(i % H, i / H)) << 2)
         | (((i % H) == H - 1) ? 2 : 0)
         | ((i == NPIX - 1) ? 1 : 0);
      chk($sformatf("m%0d_pix%0d", mode, i), 32'(acc_v[base_a + i]), 32'(ex));
      if (i == NPIX - 1) eof_idx = base_a + i;
    end
    if (eof_idx >= 0 && done_cyc.size() > base_d) begin
      chk($sformatf("m%0d_done_after_eof", mode), 32'(done_cyc[base_d]), 32'(acc_cyc[eof_idx] + 1));
    end
    if (mode == 0 && iss_cyc.size() > base_i && acc_cyc.size() > base_a) begin
      chk("m0_first_issue_cycle", 32'(iss_cyc[base_i]), 32'(fs_cyc + 1));
      chk("m0_first_valid_cycle", 32'(acc_cyc[base_a]), 32'(fs_cyc + 4));
    end
    if (mode == 3) chk("m3_tick_quiet_in_stall", 32'(stall_ticks), 32'd0);
  endtask

  initial begin
    int c;
    int dc;
    reset       = 1'b1;
    frame_start = 1'b0;
    pixel_en    = 1'b0;
    pix_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gen_x", 32'(gen_x), 32'd0);
    chk("rst_gen_y", 32'(gen_y), 32'd0);
    chk("rst_outputs", 32'({gen_tick, pix_valid, pix_data, pix_eol, pix_eof, busy, frame_done}), 32'd0);
    reset = 1'b0;

    run_frame(0, 1'b0, 1'b0);
    run_frame(3, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    chk("en_gated_issues", 32'(en_viol), 32'd0);
    run_frame(1, 1'b1, 1'b1);
    run_frame(1, 1'b0, 1'b0);

    // Mid-frame reset with three pixels parked in the FIFO.
    @(posedge clk); #1;
    frame_start = 1'b1;
    pixel_en    = 1'b1;
    pix_ready   = 1'b0;
    c = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_cycle", 32'(cyc), 32'(c + 6));
    chk("pre_reset_valid", 32'(pix_valid), 32'd1);
    frame_start = 1'b1;
    reset       = 1'b1;
    dc = done_cyc.size();
    @(posedge clk); #1;
    reset       = 1'b0;
    frame_start = 1'b0;
    chk("midrst_gen_x", 32'(gen_x), 32'd0);
    chk("midrst_gen_y", 32'(gen_y), 32'd0);
    chk("midrst_outputs", 32'({gen_tick, pix_valid, pix_data, pix_eol, pix_eof, busy, frame_done}), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cyc.size() - dc), 32'd0);
    chk("midrst_stays_idle", 32'(busy), 32'd0);
    pix_ready = 1'b1;
    run_frame(0, 1'b0, 1'b0);

    chk("max_outstanding_le4", 32'(max_out <= 4), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
